uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Bytes pushed through wr_en/wr_data are queued in a circular FIFO and
// serialized LSB-first onto the idle-high line UART_RXD_OUT, one bit every
// CLKS_PER_BIT clocks. Back-to-back queued bytes are sent with no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [7:0]                        wr_data,
    input  logic                              clr_ovf,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              busy,
    output logic                              overflow,
    output logic                              UART_RXD_OUT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf;

    // Transmitter state
    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic          tx;

    logic          push;
    logic          pop;
    logic          baud_last;

    // Status flags come straight from the registered occupancy count
    always_comb begin
        full      = (cnt == CW'(FIFO_DEPTH));
        empty     = (cnt == '0);
        baud_last = (baud == BW'(CLKS_PER_BIT - 1));
        push      = wr_en & ~full;
        // Pop when idle with data waiting, or on the final stop-bit cycle so
        // the next start bit follows without a gap.
        pop       = ~empty & ((state == S_IDLE) | ((state == S_STOP) & baud_last));
    end

    assign count        = cnt;
    assign busy         = (state != S_IDLE);
    assign overflow     = ovf;
    assign UART_RXD_OUT = tx;

    // FIFO data array write port; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overflow flag; a new drop outranks a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, one stop bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            sh      <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    baud <= '0;
                    tx   <= 1'b1;
                    if (pop) begin
                        sh    <= mem[rd_ptr];
                        state <= S_START;
                        tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx      <= sh[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= sh[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (pop) begin
                            sh    <= mem[rd_ptr];
                            state <= S_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    baud  <= '0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: table-driven single-frame check, directed
// corner-case sequences and randomized traffic against a time-based model.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          clr_ovf = 1'b0;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          busy;
    logic          overflow;
    logic          line;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .clr_ovf     (clr_ovf),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .busy        (busy),
        .overflow    (overflow),
        .UART_RXD_OUT(line)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a byte queue plus the edge number a frame started on.
    // The line level is derived from elapsed time since the frame start.
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_active;
    int         m_start;
    int         m_now;
    logic [7:0] m_cur;

    logic       samp[$];
    logic [7:0] dec[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at edge %0d", nm, act, exp, m_now);
        end
    endtask

    function automatic bit m_line();
        int idx;
        if (!m_active) return 1'b1;
        idx = (m_now - m_start) / CPB;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_active = 1'b0;
        m_start  = 0;
        m_now    = 0;
        m_cur    = 8'h00;
    endtask

    task automatic model_edge(input bit wr, input logic [7:0] d, input bit clr);
        bit was_full;
        bit had;
        was_full = (m_q.size() == DEPTH);
        had      = (m_q.size() != 0);
        m_now++;
        if (m_active && (m_now - m_start == 10 * CPB)) m_active = 1'b0;
        if (!m_active && had) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_start  = m_now;
        end
        if (wr && was_full) begin
            m_ovf = 1'b1;
        end else begin
            if (wr) m_q.push_back(d);
            if (clr) m_ovf = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("line",     int'(line),     int'(m_line()));
        chk("busy",     int'(busy),     int'(m_active));
        chk("count",    int'(count),    m_q.size());
        chk("full",     int'(full),     int'(m_q.size() == DEPTH));
        chk("empty",    int'(empty),    int'(m_q.size() == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge
    task automatic tick(input bit wr, input logic [7:0] d, input bit clr);
        wr_en   = wr;
        wr_data = d;
        clr_ovf = clr;
        @(posedge clk);
        model_edge(wr, d, clr);
        @(negedge clk);
        check_all();
        samp.push_back(line);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((busy || !empty) && n < limit) begin
            tick(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("drain_done", int'(busy || !empty), 0);
    endtask

    task automatic do_reset();
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_line",     int'(line),     1);
        chk("rst_empty",    int'(empty),    1);
        chk("rst_count",    int'(count),    0);
        chk("rst_busy",     int'(busy),     0);
        chk("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        samp.delete();
    endtask

    // Recover bytes from the sampled line: falling edge, then one sample per bit
    task automatic decode();
        int j;
        logic [7:0] b;
        dec.delete();
        j = 0;
        while (j + 9 * CPB < samp.size()) begin
            if (samp[j] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = samp[j + CPB * (k + 1)];
                dec.push_back(b);
                j += 10 * CPB;
            end else begin
                j++;
            end
        end
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] data;
        bit         clr;
        bit         exp_line;
        bit         exp_busy;
        int         exp_count;
    } vec_t;

    vec_t       vt[42];
    logic [9:0] frame10;
    int         peak;
    int         busy_cycles;

    initial begin
        // Expected waveform for one 0x41 frame: start, LSB-first data, stop
        frame10 = {1'b1, 8'h41, 1'b0};
        vt[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1};
        for (int i = 0; i < 40; i++) vt[i+1] = '{1'b0, 8'h00, 1'b0, frame10[i/CPB], 1'b1, 0};
        vt[41] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0};

        model_reset();
        #1;

        // Reset state, then held through idle cycles
        do_reset();
        idle(20);

        // Single byte from the table
        do_reset();
        for (int i = 0; i < 42; i++) begin
            tick(vt[i].wr, vt[i].data, vt[i].clr);
            chk("vec_line",  int'(line),  int'(vt[i].exp_line));
            chk("vec_busy",  int'(busy),  int'(vt[i].exp_busy));
            chk("vec_count", int'(count), vt[i].exp_count);
        end

        // Back-to-back frames
        do_reset();
        peak = 0;
        busy_cycles = 0;
        tick(1'b1, 8'h55, 1'b0);
        if (int'(count) > peak) peak = int'(count);
        if (busy) busy_cycles++;
        tick(1'b1, 8'hA3, 1'b0);
        if (int'(count) > peak) peak = int'(count);
        if (busy) busy_cycles++;
        tick(1'b1, 8'h0D, 1'b0);
        if (int'(count) > peak) peak = int'(count);
        if (busy) busy_cycles++;
        for (int n = 0; n < 300 && busy; n++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (int'(count) > peak) peak = int'(count);
            if (busy) busy_cycles++;
        end
        idle(2);
        chk("b2b_peak", peak, 2);
        chk("b2b_busy_cycles", busy_cycles, 30 * CPB);
        decode();
        chk("b2b_nframes", dec.size(), 3);
        if (dec.size() == 3) begin
            chk("b2b_byte0", int'(dec[0]), 'h55);
            chk("b2b_byte1", int'(dec[1]), 'hA3);
            chk("b2b_byte2", int'(dec[2]), 'h0D);
        end

        // Overflow while a frame is in flight
        do_reset();
        tick(1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 8'h21 + 8'(i), 1'b0);
            if (i == 3) chk("ovf_full_after_4", int'(full), 1);
        end
        chk("ovf_set", int'(overflow), 1);
        idle(10);
        chk("ovf_sticky", int'(overflow), 1);
        tick(1'b0, 8'h00, 1'b1);
        chk("ovf_cleared", int'(overflow), 0);
        drain(400);
        idle(2);
        decode();
        chk("ovf_nframes", dec.size(), 5);
        if (dec.size() == 5) begin
            chk("ovf_byte0", int'(dec[0]), 'h11);
            for (int i = 1; i < 5; i++) chk("ovf_byteN", int'(dec[i]), 'h20 + i);
        end

        // Set and clear in the same cycle: set wins
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'hB0 + 8'(i), 1'b0);
        chk("sc_full", int'(full), 1);
        tick(1'b1, 8'hEE, 1'b1);
        chk("sc_set_wins", int'(overflow), 1);
        tick(1'b0, 8'h00, 1'b1);
        chk("sc_clear", int'(overflow), 0);
        drain(400);

        // Reset in the middle of data bit 3 with two bytes queued
        do_reset();
        tick(1'b1, 8'hF0, 1'b0);
        tick(1'b1, 8'h33, 1'b0);
        tick(1'b1, 8'h44, 1'b0);
        while (m_now < m_start + 4 * CPB + 1) tick(1'b0, 8'h00, 1'b0);
        chk("mid_line_before", int'(line), 0);
        chk("mid_count_before", int'(count), 2);
        reset = 1'b1;
        #1;
        chk("mid_line_async", int'(line), 1);
        chk("mid_count_async", int'(count), 0);
        chk("mid_busy_async", int'(busy), 0);
        #1;
        reset = 1'b0;
        model_reset();
        samp.delete();
        idle(30);
        decode();
        chk("mid_no_frame", dec.size(), 0);
        tick(1'b1, 8'h5A, 1'b0);
        drain(100);

        // Randomized traffic with bursts, sparse writes and occasional clears
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            int dens;
            dens = ((i / 300) % 2 == 0) ? 70 : 8;
            tick($urandom_range(0, 99) < dens, 8'($urandom), $urandom_range(0, 39) == 0);
        end
        drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
